ps2_rx_fifo: RTL and testbench
==============================

# ps2_rx_fifo

PS/2 device-to-host frame receiver with an 8-byte show-ahead output FIFO. It is the stage directly upstream of the key-sequence / countdown logic. It synchronises the raw `ps2_clk`/`ps2_data` pins, deframes 11-bit frames, checks start, parity and stop bits, and applies an inactivity timeout. Validated scan-code bytes are buffered for a consumer that pops them with `rd_en`, and error and overflow status is exposed for game logic such as wrong-key counting.

## Interface
- `FIFO_AW`, 3, FIFO address width; depth = 2^FIFO_AW = 8 bytes.
- `TIMEOUT_CYCLES`, 100000, `clk` cycles without a falling `ps2_clk` edge mid-frame before the frame is abandoned.
- `clk`  in  1  system clock; all logic on its rising edge. Single clock domain.
- `clr`  in  1  reset; synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock pin; asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin; asynchronous.
- `rd_en`  in  1  pop request; honoured only when `valid`=1.
- `data`  out  8  FIFO head byte; meaningful only when `valid`=1. Reset value 0x00.
- `valid`  out  1  FIFO non-empty. Reset value 0.
- `overflow`  out  1  sticky flag: a good byte was dropped because the FIFO was full. Cleared only by `clr`. Reset value 0.
- `frame_err`  out  1  one-cycle pulse on a parity error, stop-bit error or timeout. Reset value 0.
- `err_count`  out  4  saturating count of `frame_err` pulses; holds at 15. Reset value 0.

## Operation
- Synchroniser:
  - `ps2_clk` passes through 3 flops; `ps2_data` passes through 2 flops.
  - Both synchroniser chains reset to all-ones (idle bus), so reset never creates an edge.
  - `fall` = stage2 & ~stage1 of the clock chain.
- States are IDLE, SHIFT and STOP, with a 4-bit bit counter `bitn` and a 9-bit shift register.
- IDLE:
  - On `fall` with data=0 (start bit): go to SHIFT with `bitn`=0.
  - On `fall` with data=1: treat as a glitch; stay in IDLE, no error.
- SHIFT:
  - Each `fall` samples data into the shift register, LSB first.
  - After 9 samples (8 data bits + parity), go to STOP.
- STOP, on `fall`: check odd parity (XOR of the 8 data bits and the parity bit = 1) and stop bit = 1.
  - Both pass: write the byte into the FIFO.
  - Either fails: pulse `frame_err` and increment `err_count`.
  - In both cases return to IDLE.
- Timeout:
  - A counter runs in SHIFT and STOP and clears on every `fall`.
  - On reaching `TIMEOUT_CYCLES`: pulse `frame_err`, increment `err_count`, go to IDLE, discard the partial frame.
  - The counter is held at 0 in IDLE.
- FIFO write:
  - Not full: the byte is stored and the write pointer advances.
  - Full: the byte is dropped and `overflow` is set.
  - Full with `rd_en`=1 in the same cycle: the pop frees a slot, so the write is accepted and `overflow` is not set.
- FIFO read:
  - `rd_en` with `valid`=1 advances the read pointer.
  - `rd_en` with `valid`=0 is ignored.
  - Pointers are FIFO_AW+1 bits wide and wrap modulo 2^(FIFO_AW+1).
  - Empty = pointers equal. Full = MSBs differ and the lower bits are equal.
- Simultaneous write and read when empty: the written byte becomes visible next cycle; the pop is ignored.
- `clr` mid-frame or with data buffered, all in one cycle:
  - state → IDLE;
  - FIFO emptied;
  - flags and `err_count` cleared;
  - synchroniser flops set to 1.

## Timing
- Pin fall to `fall` pulse: 3 `clk` cycles.
- Stop-bit `fall` cycle N → `valid`=1 and `data` = byte at N+1.
- Stop-bit `fall` cycle N → `frame_err` high during N+1 only.
- `rd_en` at cycle M → the next head byte (or `valid`=0) at M+1.
- Minimum supported `clk`/`ps2_clk` ratio: 8.
  - A PS/2 phase is at least 30 µs, so this holds easily at 50–100 MHz.
- Back-to-back frames need no idle gap: IDLE accepts a start bit on the first `fall` after STOP.

## Structure
- Package `ps2_pkg`:
  - state enum (IDLE, SHIFT, STOP);
  - `PS2_FRAME_BITS`=11;
  - `PS2_BREAK`=8'hF0 and `PS2_EXT`=8'hE0 constants for downstream decoders;
  - byte typedef.
- Sub-module `ps2_byte_fifo`: parameterised synchronous show-ahead FIFO.
  - Ports: `clk`, `clr`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`.
  - Width 8, depth 2^FIFO_AW.
- The top level holds the synchroniser, the deframer FSM, the timeout counter and the flags.

## Test plan
- Good frame: send 0x2C (start 0, bits 0,0,1,1,0,1,0,0, parity 0, stop 1) → `valid`=1, `data`=0x2C one cycle after the stop-bit fall; `frame_err`=0, `err_count`=0.
- Parity error: send 0x35 with parity 0 → `frame_err` high for exactly 1 cycle, `err_count`=1, `valid` stays 0. A following good 0xF0 (parity 1) → `data`=0xF0.
- Overflow: send 9 good bytes 0x01..0x09 with no pops → first 8 buffered, `overflow`=1. Popping 8 times yields 0x01..0x08 in order, then `valid`=0.
- Full plus simultaneous pop: FIFO full; assert `rd_en` in the stop-bit-write cycle of byte 0x4B → write accepted, `overflow` stays 0, last popped byte is 0x4B.
- Timeout: stop toggling after 4 data bits, wait `TIMEOUT_CYCLES` → one `frame_err` pulse, state back to IDLE. The next full frame 0x3A is received correctly.
- Reset mid-frame: assert `clr` after bit 5 with 3 bytes buffered → next cycle `valid`=0, `err_count`=0, `overflow`=0. Then send 0x2C → `data`=0x2C.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path and its downstream decoders.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2
  } ps2_state_t;

  typedef logic [7:0] ps2_byte_t;

  localparam int PS2_FRAME_BITS = 11;
  // Bits captured by the shift register: 8 data bits plus parity.
  localparam int PS2_SHIFT_BITS = PS2_FRAME_BITS - 2;

  localparam ps2_byte_t PS2_BREAK = 8'hF0;
  localparam ps2_byte_t PS2_EXT   = 8'hE0;

  // Odd parity over data+parity, and a high stop bit.
  function automatic logic ps2_frame_ok(input logic [8:0] data_par, input logic stop_bit);
    return (^data_par) & stop_bit;
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever not empty.
module ps2_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot a write into a full FIFO needs.
  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  // Asynchronous read keeps the head byte available without a pipeline bubble.
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit deframer with timeout,
// error/overflow status and an 8-byte show-ahead output FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err,
  output logic [3:0] err_count
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  ps2_state_t      r_state;
  ps2_state_t      w_state_next;
  logic [3:0]      r_bitn;
  logic [3:0]      w_bitn_next;
  logic [8:0]      r_shift;
  logic [8:0]      w_shift_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_next;
  logic            r_frame_err;
  logic            w_err_next;
  logic [3:0]      r_err_count;
  logic            r_overflow;
  logic            w_fall;
  logic            w_data_s;
  logic            w_timeout;
  logic            w_fifo_wr;
  ps2_byte_t       w_fifo_din;
  ps2_byte_t       w_rd_data;
  logic            w_empty;
  logic            w_full;

  // Chains reset to the idle-high bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end

  assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_data_s  = r_dat_sync[1];
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= ST_IDLE;
      r_bitn   <= '0;
      r_shift  <= '0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_bitn   <= w_bitn_next;
      r_shift  <= w_shift_next;
      r_to_cnt <= w_to_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bitn_next  = r_bitn;
    w_shift_next = r_shift;
    w_to_next    = '0;
    w_fifo_wr    = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && !w_data_s) begin
          w_state_next = ST_SHIFT;
          w_bitn_next  = '0;
        end
      end
      ST_SHIFT: begin
        if (w_fall) begin
          w_shift_next = {w_data_s, r_shift[8:1]};
          w_bitn_next  = r_bitn + 4'd1;
          if (r_bitn == 4'(PS2_SHIFT_BITS - 1)) w_state_next = ST_STOP;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b1;
        end else begin
          w_to_next = r_to_cnt + TO_W'(1);
        end
      end
      ST_STOP: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
          if (ps2_frame_ok(r_shift, w_data_s)) w_fifo_wr = 1'b1;
          else                                 w_err_next = 1'b1;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b1;
        end else begin
          w_to_next = r_to_cnt + TO_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_fifo_din = r_shift[7:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      r_frame_err <= 1'b0;
      r_err_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_err_next;
      if (w_err_next && (r_err_count != 4'hF)) r_err_count <= r_err_count + 4'd1;
      // A full FIFO is non-empty, so rd_en here is always an honoured pop.
      if (w_fifo_wr && w_full && !rd_en) r_overflow <= 1'b1;
    end
  end

  ps2_byte_fifo #(
    .WIDTH(8),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .clr    (clr),
    .wr_en  (w_fifo_wr),
    .wr_data(w_fifo_din),
    .rd_en  (rd_en),
    .rd_data(w_rd_data),
    .empty  (w_empty),
    .full   (w_full)
  );

  assign valid     = ~w_empty;
  assign data      = w_empty ? 8'h00 : w_rd_data;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: vector table, directed corner sequences
// and randomized frames against a queue-based reference model.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int TO = 200;
  localparam int HP = 10;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       overflow;
  logic       frame_err;
  logic [3:0] err_count;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_AW(3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .clr(clr), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .data(data), .valid(valid), .overflow(overflow), .frame_err(frame_err),
    .err_count(err_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic       s_err_n2, s_err_n3, s_err_n4, s_valid_n3;
  logic [7:0] s_data_n3;

  typedef struct {
    logic [10:0] frame;
    int          nbits;
    bit          exp_valid;
    logic [7:0]  exp_data;
    bit          exp_err;
    logic [3:0]  exp_errc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_bad, input bit stop);
    logic p;
    p = ~^b;
    if (par_bad) p = ~p;
    return {stop, p, b, 1'b0};
  endfunction

  // Sends bits[0..n-1]; snapshots outputs 2, 3 and 4 negedges after the last pin fall.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_last);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(negedge clk);
      s_err_n2 = frame_err;
      if (pop_at_last && (i == n - 1)) rd_en = 1'b1;
      @(negedge clk);
      rd_en      = 1'b0;
      s_err_n3   = frame_err;
      s_valid_n3 = valid;
      s_data_n3  = data;
      @(negedge clk);
      s_err_n4 = frame_err;
      repeat (HP - 4) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HP) @(negedge clk);
  endtask

  task automatic pop_chk(input string name, input bit exp_v, input logic [7:0] exp_d);
    chk({name, " valid"}, 32'(valid), 32'(exp_v));
    if (exp_v) chk({name, " data"}, 32'(data), 32'(exp_d));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    bit         ovf_m;
    int         errc_m;
    int         hi, first;

    vecs[0] = '{mk_frame(8'h2C, 1'b0, 1'b1),     11, 1'b1, 8'h2C,     1'b0, 4'd0};
    vecs[1] = '{mk_frame(8'h35, 1'b1, 1'b1),     11, 1'b0, 8'h00,     1'b1, 4'd1};
    vecs[2] = '{mk_frame(PS2_BREAK, 1'b0, 1'b1), 11, 1'b1, PS2_BREAK, 1'b0, 4'd1};
    vecs[3] = '{mk_frame(8'hA5, 1'b0, 1'b0),     11, 1'b0, 8'h00,     1'b1, 4'd2};
    vecs[4] = '{11'h001,                          1, 1'b0, 8'h00,     1'b0, 4'd2};
    vecs[5] = '{mk_frame(PS2_EXT, 1'b0, 1'b1),   11, 1'b1, PS2_EXT,   1'b0, 4'd2};
    vecs[6] = '{mk_frame(8'h00, 1'b0, 1'b1),     11, 1'b1, 8'h00,     1'b0, 4'd2};
    vecs[7] = '{mk_frame(8'hFF, 1'b0, 1'b1),     11, 1'b1, 8'hFF,     1'b0, 4'd2};

    repeat (4) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("reset valid", 32'(valid), 0);
    chk("reset data", 32'(data), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    chk("reset err_count", 32'(err_count), 0);

    // Table-driven frames, FIFO drained after each.
    for (int v = 0; v < 8; v++) begin
      send_bits(vecs[v].frame, vecs[v].nbits, 1'b0);
      chk("vec valid", 32'(s_valid_n3), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk("vec data", 32'(s_data_n3), 32'(vecs[v].exp_data));
      chk("vec err pulse", 32'({s_err_n2, s_err_n3, s_err_n4}), 32'({1'b0, vecs[v].exp_err, 1'b0}));
      chk("vec err_count", 32'(err_count), 32'(vecs[v].exp_errc));
      chk("vec overflow", 32'(overflow), 0);
      $display("vec %0d frame=%03h valid=%0b data=%02h err=%0b errc=%0d",
               v, vecs[v].frame, s_valid_n3, s_data_n3, s_err_n3, err_count);
      if (vecs[v].exp_valid) pop_chk("vec pop", 1'b1, vecs[v].exp_data);
      chk("vec drained", 32'(valid), 0);
    end

    // Overflow: nine bytes, no pops.
    do_clr();
    for (int i = 1; i <= 9; i++) send_bits(mk_frame(8'(i), 1'b0, 1'b1), 11, 1'b0);
    chk("ovf flag", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) pop_chk("ovf pop", 1'b1, 8'(i));
    chk("ovf empty", 32'(valid), 0);
    chk("ovf sticky", 32'(overflow), 1);
    $display("overflow sequence done overflow=%0b", overflow);

    // Full FIFO with a pop in the write cycle of 0x4B.
    do_clr();
    for (int i = 0; i < 8; i++) send_bits(mk_frame(8'h11 + 8'(i), 1'b0, 1'b1), 11, 1'b0);
    send_bits(mk_frame(8'h4B, 1'b0, 1'b1), 11, 1'b1);
    chk("fullpop overflow", 32'(overflow), 0);
    for (int i = 0; i < 7; i++) pop_chk("fullpop pop", 1'b1, 8'h12 + 8'(i));
    pop_chk("fullpop last", 1'b1, 8'h4B);
    chk("fullpop empty", 32'(valid), 0);
    $display("full+pop sequence done overflow=%0b", overflow);

    // Timeout after start + 4 data bits.
    do_clr();
    send_bits(mk_frame(8'h3A, 1'b0, 1'b1), 5, 1'b0);
    hi = 0;
    first = -1;
    for (int c = 0; c < TO + 60; c++) begin
      @(negedge clk);
      if (frame_err) begin
        hi++;
        if (first < 0) first = c;
      end
    end
    chk("timeout pulses", 32'(hi), 1);
    chk("timeout window", 32'((first >= TO - 2 * HP - 10) && (first <= TO)), 1);
    chk("timeout err_count", 32'(err_count), 1);
    chk("timeout valid", 32'(valid), 0);
    send_bits(mk_frame(8'h3A, 1'b0, 1'b1), 11, 1'b0);
    chk("post-timeout valid", 32'(s_valid_n3), 1);
    chk("post-timeout data", 32'(s_data_n3), 32'h3A);
    $display("timeout sequence first_err=%0d data=%02h", first, s_data_n3);

    // Reset mid-frame with bytes buffered and a nonzero error count.
    do_clr();
    send_bits(mk_frame(8'h35, 1'b1, 1'b1), 11, 1'b0);
    for (int i = 0; i < 3; i++) send_bits(mk_frame(8'h61 + 8'(i), 1'b0, 1'b1), 11, 1'b0);
    send_bits(mk_frame(8'h77, 1'b0, 1'b1), 6, 1'b0);
    chk("pre-clr valid", 32'(valid), 1);
    chk("pre-clr err_count", 32'(err_count), 1);
    do_clr();
    chk("clr valid", 32'(valid), 0);
    chk("clr err_count", 32'(err_count), 0);
    chk("clr overflow", 32'(overflow), 0);
    send_bits(mk_frame(8'h2C, 1'b0, 1'b1), 11, 1'b0);
    chk("post-clr valid", 32'(s_valid_n3), 1);
    chk("post-clr data", 32'(s_data_n3), 32'h2C);
    chk("post-clr err", 32'(s_err_n3), 0);
    $display("reset-mid-frame sequence data=%02h", s_data_n3);

    // Randomized frames against a queue model.
    do_clr();
    q.delete();
    ovf_m  = 1'b0;
    errc_m = 0;
    for (int r = 0; r < 60; r++) begin
      int         kind;
      logic [7:0] b;
      bit         exp_e;
      int         npop;
      kind  = $urandom_range(0, 9);
      b     = 8'($urandom);
      exp_e = 1'b0;
      case (kind)
        0: begin send_bits(mk_frame(b, 1'b1, 1'b1), 11, 1'b0); exp_e = 1'b1; end
        1: begin send_bits(mk_frame(b, 1'b0, 1'b0), 11, 1'b0); exp_e = 1'b1; end
        2: begin send_bits(mk_frame(b, 1'b1, 1'b0), 11, 1'b0); exp_e = 1'b1; end
        3: send_bits(11'h7FF, 1, 1'b0);
        default: begin
          send_bits(mk_frame(b, 1'b0, 1'b1), 11, 1'b0);
          if (q.size() < 8) q.push_back(b);
          else              ovf_m = 1'b1;
        end
      endcase
      if (exp_e && errc_m < 15) errc_m++;
      chk("rnd err pulse", 32'(s_err_n3), 32'(exp_e));
      chk("rnd valid", 32'(valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd data", 32'(data), 32'(q[0]));
      chk("rnd overflow", 32'(overflow), 32'(ovf_m));
      chk("rnd err_count", 32'(err_count), 32'(errc_m));
      $display("rnd %0d kind=%0d byte=%02h depth=%0d errc=%0d ovf=%0b",
               r, kind, b, q.size(), err_count, overflow);
      npop = $urandom_range(0, 3);
      for (int p = 0; p < npop; p++) begin
        if (q.size() != 0) begin
          pop_chk("rnd pop", 1'b1, q[0]);
          void'(q.pop_front());
        end else begin
          pop_chk("rnd pop empty", 1'b0, 8'h00);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
